// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl -- instruction fetch sequencer for the RV32I core.
//
// Owns the architectural PC, issues one request at a time to instruction
// memory over a req/gnt/rvalid handshake, and hands fetched words to decode
// through a single-entry valid/ready buffer. Redirects load a new PC and
// cause any in-flight response to be discarded. A misaligned redirect target
// raises a one-cycle misalign pulse and parks the block until an aligned
// redirect arrives.
//
// Optional build macro: FETCH_PERF_CNT_EN
//   defined   -> perf_fetch_cnt_o / perf_kill_cnt_o are saturating 32-bit
//                counters of granted requests / discarded responses.
//   undefined -> both ports are tied to zero and no counter flops exist.
//
// Ports:
//   clk_i, rst_ni              clock (rising edge), async active-low reset
//   imem_req_o, imem_addr_o    fetch request and address (address = PC)
//   imem_gnt_i                 request accepted this cycle
//   imem_rvalid_i, imem_rdata_i response strobe and instruction word
//   instr_valid_o, instr_o,
//   instr_pc_o, instr_ready_i  output buffer towards decode
//   redirect_valid_i,
//   redirect_pc_i              load a new PC (branch/jump target)
//   halt_i                     stop issuing new fetches
//   misalign_o                 one-cycle pulse for a misaligned redirect
//   perf_fetch_cnt_o,
//   perf_kill_cnt_o            performance counters (see macro above)

module fetch_pc_ctrl #(
    parameter int unsigned           ADDR_WIDTH   = 32,
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    output logic                  imem_req_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_gnt_i,
    input  logic                  imem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    output logic                  instr_valid_o,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] instr_pc_o,
    input  logic                  instr_ready_i,
    input  logic                  redirect_valid_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    input  logic                  halt_i,
    output logic                  misalign_o,
    output logic [31:0]           perf_fetch_cnt_o,
    output logic [31:0]           perf_kill_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HALT
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  kill_q, kill_d;
    logic                  buf_valid_q, buf_valid_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
    logic                  misalign_q, misalign_d;
    // Set by a misaligned redirect; holds the block in HALT regardless of
    // halt_i until an aligned redirect clears it.
    logic                  mis_halt_q, mis_halt_d;

    logic redir_mis;
    logic redir_ok;
    logic buf_free;
    logic req;
    logic req_gnt;
    logic resp;
    logic load;
    logic discard;

    assign redir_mis = redirect_valid_i & (redirect_pc_i[1:0] != 2'b00);
    assign redir_ok  = redirect_valid_i & ~redir_mis;

    // The buffer can accept a new word if it is empty or drains this cycle.
    assign buf_free  = ~buf_valid_q | instr_ready_i;
    assign req       = (state_q == S_REQ) & buf_free & ~halt_i;
    assign req_gnt   = req & imem_gnt_i;
    assign resp      = (state_q == S_WAIT) & imem_rvalid_i;

    // A response is stale if it was killed earlier or a redirect lands in
    // the same cycle; in the latter case kill_q never needs to be set.
    assign load      = resp & ~kill_q & ~redirect_valid_i;
    assign discard   = resp & (kill_q | redirect_valid_i);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        kill_d      = kill_q;
        buf_valid_d = buf_valid_q;
        instr_d     = instr_q;
        instr_pc_d  = instr_pc_q;
        misalign_d  = redir_mis;
        mis_halt_d  = mis_halt_q;

        if (redir_mis) begin
            mis_halt_d = 1'b1;
        end else if (redir_ok) begin
            mis_halt_d = 1'b0;
        end

        // Buffer: consume, then load (load wins), then redirect flush (wins).
        if (buf_valid_q && instr_ready_i) begin
            buf_valid_d = 1'b0;
        end
        if (load) begin
            buf_valid_d = 1'b1;
            instr_d     = imem_rdata_i;
            instr_pc_d  = pc_q;
            pc_d        = pc_q + ADDR_WIDTH'(4);
        end
        if (redirect_valid_i) begin
            buf_valid_d = 1'b0;
        end
        if (redir_ok) begin
            pc_d = redirect_pc_i;
        end

        case (state_q)
            S_IDLE: begin
                state_d = (halt_i || mis_halt_d) ? S_HALT : S_REQ;
            end
            S_REQ: begin
                if (req_gnt) begin
                    state_d = S_WAIT;
                    if (redirect_valid_i) begin
                        kill_d = 1'b1;
                    end
                end else if (mis_halt_d) begin
                    state_d = S_HALT;
                end
            end
            S_WAIT: begin
                if (resp) begin
                    kill_d  = 1'b0;
                    state_d = (halt_i || mis_halt_d) ? S_HALT : S_REQ;
                end else if (redirect_valid_i) begin
                    kill_d = 1'b1;
                end
            end
            S_HALT: begin
                if (!halt_i && !mis_halt_d) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_VECTOR;
            kill_q      <= 1'b0;
            buf_valid_q <= 1'b0;
            instr_q     <= '0;
            instr_pc_q  <= '0;
            misalign_q  <= 1'b0;
            mis_halt_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            kill_q      <= kill_d;
            buf_valid_q <= buf_valid_d;
            instr_q     <= instr_d;
            instr_pc_q  <= instr_pc_d;
            misalign_q  <= misalign_d;
            mis_halt_q  <= mis_halt_d;
        end
    end

    assign imem_req_o    = req;
    assign imem_addr_o   = pc_q;
    assign instr_valid_o = buf_valid_q;
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
    assign misalign_o    = misalign_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_kill_q, perf_kill_d;

    // Both counters saturate instead of wrapping.
    always_comb begin
        perf_fetch_d = perf_fetch_q;
        perf_kill_d  = perf_kill_q;
        if (req_gnt && (perf_fetch_q != 32'hFFFF_FFFF)) begin
            perf_fetch_d = perf_fetch_q + 32'd1;
        end
        if (discard && (perf_kill_q != 32'hFFFF_FFFF)) begin
            perf_kill_d = perf_kill_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_fetch_q <= '0;
            perf_kill_q  <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_kill_q  <= perf_kill_d;
        end
    end

    assign perf_fetch_cnt_o = perf_fetch_q;
    assign perf_kill_cnt_o  = perf_kill_q;
`else
    logic unused_discard;
    assign unused_discard   = discard;
    assign perf_fetch_cnt_o = '0;
    assign perf_kill_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Bench for fetch_pc_ctrl: directed stimulus, a transaction-level model of
// the fetch unit (PC, outstanding/drop flags, buffer, parked flag) and an
// imem responder driven from that model.
module tb_fetch_pc_ctrl;

    localparam int          AW = 32;
    localparam int          DW = 32;
    localparam logic [31:0] RV = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          imem_req, imem_gnt, imem_rvalid;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_rdata;
    logic          instr_valid, instr_ready;
    logic [DW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          redirect_valid, halt, misalign;
    logic [AW-1:0] redirect_pc;
    logic [31:0]   perf_fetch, perf_kill;

    fetch_pc_ctrl #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .RESET_VECTOR(RV)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .imem_req_o      (imem_req),
        .imem_addr_o     (imem_addr),
        .imem_gnt_i      (imem_gnt),
        .imem_rvalid_i   (imem_rvalid),
        .imem_rdata_i    (imem_rdata),
        .instr_valid_o   (instr_valid),
        .instr_o         (instr),
        .instr_pc_o      (instr_pc),
        .instr_ready_i   (instr_ready),
        .redirect_valid_i(redirect_valid),
        .redirect_pc_i   (redirect_pc),
        .halt_i          (halt),
        .misalign_o      (misalign),
        .perf_fetch_cnt_o(perf_fetch),
        .perf_kill_cnt_o (perf_kill)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Responder controls
    bit gnt_en;
    bit rv_force;
    int lat;

    // Model state
    logic [31:0] m_pc, m_bi, m_bpc, m_raddr;
    bit          m_idle, m_park, m_lock, m_out, m_drop, m_bv, m_mis;
    int          m_age;
    logic [31:0] m_fcnt, m_kcnt;

    logic [31:0] gnt_addr[$];
    int          gnt_cyc[$];
    logic [31:0] dlv_pc[$];

    function automatic logic [31:0] instr_of(logic [31:0] a);
        return a ^ 32'h1301_0013;
    endfunction

    function automatic logic [31:0] at_gnt(int i);
        return (i >= 0 && i < gnt_addr.size()) ? gnt_addr[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic int at_cyc(int i);
        return (i >= 0 && i < gnt_cyc.size()) ? gnt_cyc[i] : -1000;
    endfunction

    function automatic logic [31:0] at_dlv(int i);
        return (i >= 0 && i < dlv_pc.size()) ? dlv_pc[i] : 32'hFFFF_FFFF;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_pc = RV; m_bi = '0; m_bpc = '0; m_raddr = '0;
        m_idle = 1; m_park = 0; m_lock = 0; m_out = 0; m_drop = 0;
        m_bv = 0; m_mis = 0; m_age = 0; m_fcnt = '0; m_kcnt = '0;
    endtask

    // A request may go out once started, not parked, nothing outstanding,
    // room in the buffer and no halt.
    function automatic bit exp_req();
        return !m_idle && !m_park && !m_out && (!m_bv || instr_ready) && !halt;
    endfunction

    task automatic model_step();
        bit rq, gr, rs, rd, ms, ld, out_n, lock_n;
        logic [31:0] pc0;
        pc0 = m_pc;
        rq = exp_req();
        gr = rq && imem_gnt;
        rs = m_out && imem_rvalid;
        rd = redirect_valid;
        ms = rd && (redirect_pc[1:0] != 2'b00);
        m_mis = ms;
        if (gr && m_fcnt != 32'hFFFF_FFFF) m_fcnt = m_fcnt + 1;
        if (rs && (m_drop || rd) && m_kcnt != 32'hFFFF_FFFF) m_kcnt = m_kcnt + 1;
        ld = rs && !m_drop && !rd;
        if (rd) m_bv = 0;
        else if (ld) begin
            m_bv = 1; m_bi = imem_rdata; m_bpc = pc0; dlv_pc.push_back(pc0);
        end else if (m_bv && instr_ready) m_bv = 0;
        if (ld) m_pc = pc0 + 4;
        else if (rd && !ms) m_pc = redirect_pc;
        out_n = (m_out && !rs) || gr;
        if (rs) m_drop = 0;
        else if (rd && out_n) m_drop = 1;
        lock_n = ms ? 1'b1 : (rd ? 1'b0 : m_lock);
        if (m_idle || m_park) m_park = halt || lock_n;
        else if (rs) m_park = halt || lock_n;
        else if (!out_n) m_park = lock_n;
        m_idle = 0;
        if (gr) begin
            m_raddr = pc0; m_age = 0;
            gnt_addr.push_back(pc0); gnt_cyc.push_back(cyc);
        end else if (m_out && !rs) m_age++;
        m_out = out_n;
        m_lock = lock_n;
    endtask

    task automatic drive_and_check();
        imem_gnt    = gnt_en;
        imem_rvalid = rv_force || (m_out && m_age >= lat);
        imem_rdata  = m_out ? instr_of(m_raddr) : 32'hBAD0_BAD0;
        #1;
        chk("req", imem_req, exp_req());
        chk("addr", imem_addr, m_pc);
        chk("valid", instr_valid, m_bv);
        chk("instr", instr, m_bi);
        chk("instr_pc", instr_pc, m_bpc);
        chk("misalign", misalign, m_mis);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetch", perf_fetch, m_fcnt);
        chk("perf_kill", perf_kill, m_kcnt);
`else
        chk("perf_fetch", perf_fetch, 32'h0);
        chk("perf_kill", perf_kill, 32'h0);
`endif
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic tick();
        drive_and_check();
        advance();
    endtask

    task automatic wait_grant();
        int n0;
        int k;
        n0 = gnt_addr.size();
        k = 0;
        while (gnt_addr.size() == n0 && k < 30) begin
            tick();
            k++;
        end
        chk("wait_grant_done", 32'(gnt_addr.size() != n0), 32'h1);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (m_out && k < 30) begin
            tick();
            k++;
        end
        chk("wait_resp_done", 32'(m_out), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int found;
        instr_ready = 1; redirect_valid = 0; redirect_pc = '0; halt = 0;
        gnt_en = 1; lat = 1; rv_force = 0;
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
        model_reset();
        rst_n = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", imem_req, 32'h0);
        chk("rst_addr", imem_addr, RV);
        chk("rst_valid", instr_valid, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_mis", misalign, 32'h0);
        chk("rst_perf", perf_fetch | perf_kill, 32'h0);
        @(negedge clk);
        rst_n = 1;

        // Sequential fetch, latency 1 after grant
        repeat (10) tick();
        chk("seq_gnt0", at_gnt(0), 32'h0);
        chk("seq_gnt1", at_gnt(1), 32'h4);
        chk("seq_gnt2", at_gnt(2), 32'h8);
        chk("seq_spacing", 32'(at_cyc(1) - at_cyc(0)), 32'd3);
        chk("seq_dlv0", at_dlv(0), 32'h0);
        chk("seq_dlv1", at_dlv(1), 32'h4);
        chk("seq_dlv2", at_dlv(2), 32'h8);

        // Backpressure from decode
        instr_ready = 0;
        repeat (3) tick();
        drive_and_check();
        chk("hold_req", imem_req, 32'h0);
        chk("hold_valid", instr_valid, 32'h1);
        chk("hold_pc", instr_pc, 32'h8);
        advance();
        instr_ready = 1;
        drive_and_check();
        chk("release_req", imem_req, 32'h1);
        chk("release_addr", imem_addr, 32'hC);
        advance();

        // Redirect while waiting for 0xC
        redirect_valid = 1; redirect_pc = 32'h100;
        tick();
        redirect_valid = 0;
        wait_grant();
        chk("redir_wait_addr", at_gnt(gnt_addr.size() - 1), 32'h100);
`ifdef FETCH_PERF_CNT_EN
        chk("redir_wait_kill", perf_kill, 32'h1);
`endif
        wait_idle();
        found = 0;
        foreach (dlv_pc[i]) if (dlv_pc[i] == 32'hC) found++;
        chk("no_stale_0xC", 32'(found), 32'h0);

        // Redirect in REQ without grant
        gnt_en = 0;
        tick();
        redirect_valid = 1; redirect_pc = 32'h200;
        tick();
        redirect_valid = 0;
        drive_and_check();
        chk("redir_req_addr", imem_addr, 32'h200);
        chk("redir_req_req", imem_req, 32'h1);
        advance();
        gnt_en = 1;
        wait_grant();
        chk("redir_req_gnt", at_gnt(gnt_addr.size() - 1), 32'h200);
        gnt_en = 0;
        wait_idle();

        // Misaligned redirect, then recover with an aligned one
        redirect_valid = 1; redirect_pc = 32'h202;
        tick();
        redirect_valid = 0;
        drive_and_check();
        chk("mis_pulse", misalign, 32'h1);
        chk("mis_pc_kept", imem_addr, 32'h204);
        advance();
        drive_and_check();
        chk("mis_pulse_end", misalign, 32'h0);
        advance();
        gnt_en = 1;
        repeat (4) tick();
        drive_and_check();
        chk("mis_parked", imem_req, 32'h0);
        advance();
        redirect_valid = 1; redirect_pc = 32'h300;
        tick();
        redirect_valid = 0;
        wait_grant();
        chk("mis_resume", at_gnt(gnt_addr.size() - 1), 32'h300);

        // halt_i while waiting: response still delivered, then stop
        halt = 1;
        wait_idle();
        chk("halt_dlv", at_dlv(dlv_pc.size() - 1), 32'h300);
        repeat (4) tick();
        drive_and_check();
        chk("halt_noreq", imem_req, 32'h0);
        advance();
        halt = 0;
        wait_grant();
        chk("halt_next", at_gnt(gnt_addr.size() - 1), 32'h304);

        // Reset in the middle of a transaction; late response ignored
        rst_n = 0;
        model_reset();
        #1;
        chk("mid_rst_req", imem_req, 32'h0);
        chk("mid_rst_valid", instr_valid, 32'h0);
        chk("mid_rst_addr", imem_addr, RV);
        @(negedge clk);
        rst_n = 1;
        rv_force = 1;
        tick();
        rv_force = 0;
        wait_grant();
        chk("post_rst_gnt", at_gnt(gnt_addr.size() - 1), RV);
        wait_idle();
        tick();
        chk("post_rst_dlv", at_dlv(dlv_pc.size() - 1), RV);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
